// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM states and
// the default operand width.
//
// Contents:
//   DEFAULT_W : default operand width in bits
//   OP_WIDTH  : opcode width (fixed at 2)
//   op_e      : opcode encoding (SUB, MUL, ADD, CMP)
//   state_e   : control FSM states (IDLE, MUL, HOLD)
package alu_pkg;

    localparam int DEFAULT_W = 3;
    localparam int OP_WIDTH  = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_SUB = 2'b00,
        OP_MUL = 2'b01,
        OP_ADD = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/alu_shift_mul.sv
// Iterative shift-add multiplier datapath for the sequential ALU.
// A start strobe latches the operands; W enabled steps later the product is
// presented combinationally together with a one-cycle done strobe, so the
// owner can register the result on the same edge as the final step.
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, aborts any multiply in progress
//   en      : step enable; when low all state freezes
//   start   : load operands and begin a multiply
//   a, b    : unsigned operands (W bits)
//   busy    : multiply in progress
//   done    : final step happens on the coming edge
//   product : a * b, valid while done is high (2W bits)
module alu_shift_mul #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [2*W-1:0] a_sh;
    logic [W-1:0]   b_sh;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [CW-1:0]  cnt;
    logic           running;

    // The accumulator value after the current step is also the product when
    // the step is the last one, which gives the owner zero extra latency.
    always_comb begin
        acc_next = acc + (b_sh[0] ? a_sh : '0);
        done     = en && running && (cnt == LAST);
        product  = acc_next;
        busy     = running;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (en) begin
            if (start) begin
                a_sh    <= {{W{1'b0}}, a};
                b_sh    <= b;
                acc     <= '0;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                acc  <= acc_next;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
                if (cnt == LAST) begin
                    running <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshakes on both sides, carry and zero
// flags. ADD/SUB/CMP complete on the accept edge; MUL runs W steps in the
// shift-add sub-module. Results are held until the consumer takes them.
//
// Build option: define ALU_SAT_SUB_EN to make SUB saturate at zero instead of
// wrapping modulo 2^(2W). CMP is the same in both builds.
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   en            : block enable; low freezes all state and blocks accepts
//   op            : 00 SUB, 01 MUL, 10 ADD, 11 CMP
//   in_valid      : a, b and op are valid
//   in_ready      : block can accept an operation
//   a, b          : unsigned operands (W bits)
//   out_valid     : dout and flags hold a result
//   out_ready     : consumer accepts the result
//   dout          : result (2W bits)
//   carry         : ADD carry-out, SUB/CMP borrow, MUL upper half nonzero
//   zero          : dout == 0, or a == b for CMP
//   busy          : multiply in progress
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int W   = DEFAULT_W,
    parameter int OPW = OP_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [OPW-1:0] op,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] dout,
    output logic           carry,
    output logic           zero,
    output logic           busy
);

    state_e         state, state_next;
    logic [2*W-1:0] dout_next;
    logic           carry_next, zero_next, valid_next;
    logic           accept, mul_start, mul_done;
    logic [2*W-1:0] a_ext, b_ext, sum, diff, mul_product;
    logic           a_lt_b;

    assign in_ready = en && (state == IDLE) && !out_valid;
    assign accept   = in_valid && in_ready;

    assign a_ext  = {{W{1'b0}}, a};
    assign b_ext  = {{W{1'b0}}, b};
    assign sum    = a_ext + b_ext;
    assign diff   = a_ext - b_ext;
    assign a_lt_b = (a < b);

    alu_shift_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Next-state and result logic. Everything holds by default, so an idle
    // or backpressured cycle changes nothing.
    always_comb begin
        state_next = state;
        dout_next  = dout;
        carry_next = carry;
        zero_next  = zero;
        valid_next = out_valid;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_e'(op))
                        OP_ADD: begin
                            dout_next  = sum;
                            carry_next = sum[W];
                            zero_next  = (sum == '0);
                            valid_next = 1'b1;
                            state_next = HOLD;
                        end
                        OP_SUB: begin
`ifdef ALU_SAT_SUB_EN
                            if (a_lt_b) begin
                                dout_next  = '0;
                                carry_next = 1'b1;
                                zero_next  = 1'b1;
                            end else begin
                                dout_next  = diff;
                                carry_next = 1'b0;
                                zero_next  = (diff == '0);
                            end
`else
                            dout_next  = diff;
                            carry_next = a_lt_b;
                            zero_next  = (diff == '0);
`endif
                            valid_next = 1'b1;
                            state_next = HOLD;
                        end
                        OP_CMP: begin
                            dout_next  = '0;
                            carry_next = a_lt_b;
                            zero_next  = (a == b);
                            valid_next = 1'b1;
                            state_next = HOLD;
                        end
                        OP_MUL: begin
                            mul_start  = 1'b1;
                            state_next = MUL;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (mul_done) begin
                    dout_next  = mul_product;
                    carry_next = |mul_product[2*W-1:W];
                    zero_next  = (mul_product == '0);
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers; en low freezes the whole block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dout      <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            state     <= state_next;
            dout      <= dout_next;
            carry     <= carry_next;
            zero      <= zero_next;
            out_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at W = 3. Inputs change 1ns
// after a rising edge and outputs are sampled at that same point.
module tb_alu_seq_core;

    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b1;
    logic [1:0]     op = 2'b00;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] dout;
    logic           carry;
    logic           zero;
    logic           busy;

    int total = 0;
    int bad   = 0;

    alu_seq_core #(.W(W), .OPW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and returns just after its accept edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        int waited;
        op = o;
        a = va;
        b = vb;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            cycle();
            waited++;
        end
        if (!in_ready) checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid appears (bounded).
    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
    endtask

    // Single-edge operation with out_ready high: result after the accept
    // edge, handoff on the next edge.
    task automatic runSingle(input string tag, input logic [1:0] o, input logic [W-1:0] va,
                             input logic [W-1:0] vb, input int expD, input int expC, input int expZ);
        applyStimulus(o, va, vb);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".dout"}, 32'(dout), 32'(expD));
        checkOutput({tag, ".carry"}, 32'(carry), 32'(expC));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expZ));
        cycle();
        checkOutput({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    task automatic runMul(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int expD, input int expC, input int expZ);
        int lat;
        applyStimulus(2'b01, va, vb);
        for (int i = 0; i < W; i++) begin
            checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
            checkOutput({tag, ".inReady"}, 32'(in_ready), 32'd0);
            checkOutput({tag, ".earlyValid"}, 32'(out_valid), 32'd0);
            cycle();
        end
        lat = W;
        if (!out_valid) begin
            waitValid(lat);
            lat = lat + W;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(W));
        checkOutput({tag, ".dout"}, 32'(dout), 32'(expD));
        checkOutput({tag, ".carry"}, 32'(carry), 32'(expC));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expZ));
        checkOutput({tag, ".busyDone"}, 32'(busy), 32'd0);
        cycle();
        checkOutput({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seenValid;

        // Reset state
        #12;
        checkOutput("rst.dout", 32'(dout), 32'd0);
        checkOutput("rst.valid", 32'(out_valid), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.carry", 32'(carry), 32'd0);
        checkOutput("rst.zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        cycle();
        checkOutput("rst.inReady", 32'(in_ready), 32'd1);

        // ADD / SUB / CMP
        runSingle("add5_6", 2'b10, 3'd5, 3'd6, 11, 1, 0);
        checkOutput("add5_6.readyAgain", 32'(in_ready), 32'd1);
        runSingle("add7_7", 2'b10, 3'd7, 3'd7, 14, 1, 0);
        runSingle("add0_0", 2'b10, 3'd0, 3'd0, 0, 0, 1);
`ifdef ALU_SAT_SUB_EN
        runSingle("sub2_5", 2'b00, 3'd2, 3'd5, 0, 1, 1);
`else
        runSingle("sub2_5", 2'b00, 3'd2, 3'd5, 61, 1, 0);
`endif
        runSingle("sub6_2", 2'b00, 3'd6, 3'd2, 4, 0, 0);
        runSingle("cmp4_4", 2'b11, 3'd4, 3'd4, 0, 0, 1);
        runSingle("cmp1_6", 2'b11, 3'd1, 3'd6, 0, 1, 0);
        runSingle("cmp6_1", 2'b11, 3'd6, 3'd1, 0, 0, 0);

        // MUL
        runMul("mul7_7", 3'd7, 3'd7, 49, 1, 0);
        runMul("mul3_0", 3'd3, 3'd0, 0, 0, 1);
        runMul("mul2_3", 3'd2, 3'd3, 6, 0, 0);
        runMul("mul5_6", 3'd5, 3'd6, 30, 1, 0);

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        applyStimulus(2'b10, 3'd3, 3'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.valid", 32'(out_valid), 32'd1);
            checkOutput("bp.dout", 32'(dout), 32'd5);
            checkOutput("bp.inReady", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        checkOutput("bp.drop", 32'(out_valid), 32'd0);
        checkOutput("bp.readyAgain", 32'(in_ready), 32'd1);
        applyStimulus(2'b10, 3'd1, 3'd1);
        checkOutput("bp.nextDout", 32'(dout), 32'd2);
        cycle();

        // en low in HOLD: handoff waits for enable
        applyStimulus(2'b10, 3'd1, 3'd2);
        en = 1'b0;
        cycle();
        checkOutput("enHold.valid", 32'(out_valid), 32'd1);
        checkOutput("enHold.dout", 32'(dout), 32'd3);
        checkOutput("enHold.inReady", 32'(in_ready), 32'd0);
        en = 1'b1;
        cycle();
        checkOutput("enHold.drop", 32'(out_valid), 32'd0);

        // en low for 2 cycles mid-MUL: completion slips by exactly 2
        applyStimulus(2'b01, 3'd6, 3'd5);
        cycle();
        en = 1'b0;
        cycle();
        cycle();
        checkOutput("enMul.busy", 32'(busy), 32'd1);
        checkOutput("enMul.valid", 32'(out_valid), 32'd0);
        en = 1'b1;
        waitValid(lat);
        checkOutput("enMul.latency", 32'(lat + 3), 32'(W + 2));
        checkOutput("enMul.dout", 32'(dout), 32'd30);
        cycle();

        // Reset mid-MUL: asynchronous clear, no result afterwards
        applyStimulus(2'b01, 3'd7, 3'd7);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstMul.dout", 32'(dout), 32'd0);
        checkOutput("rstMul.busy", 32'(busy), 32'd0);
        checkOutput("rstMul.valid", 32'(out_valid), 32'd0);
        checkOutput("rstMul.carry", 32'(carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seenValid = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (out_valid) seenValid++;
        end
        checkOutput("rstMul.noResult", 32'(seenValid), 32'd0);
        checkOutput("rstMul.inReady", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised successor of the team's 3-bit registered adder ALU.
- Generalises operand width; adds SUB, CMP and a multi-cycle shift-add MUL.
- Adds a valid/ready handshake on input and output, plus carry and zero flags.
- Sits between the operand register file and the result bus. Upstream control presents one operation at a time; downstream consumes the results.

Parameters:
- W, 3: operand width in bits, W >= 2.
- OPW, 2: opcode width; fixed at 2, exposed for the package.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: block enable; when low, all state freezes.
- op, input, 2: opcode. 2'b00 SUB, 2'b01 MUL, 2'b10 ADD, 2'b11 CMP.
- in_valid, input, 1: operands and op are valid.
- in_ready, output, 1: block can accept an operation.
- a, input, W: operand A, unsigned.
- b, input, W: operand B, unsigned.
- out_valid, output, 1: dout and flags hold a result.
- out_ready, input, 1: consumer accepts the result.
- dout, output, 2W: result.
- carry, output, 1: ADD carry-out, SUB/CMP borrow (a < b), MUL upper-half nonzero.
- zero, output, 1: dout == 0; for CMP, a == b.
- busy, output, 1: multiply in progress.

Behaviour:
- Reset (async, rst_n low): state IDLE, dout = 0, carry = 0, zero = 0, out_valid = 0, busy = 0. The multiply counter and accumulator clear. Asserting reset mid-multiply aborts the operation; no result is produced.
- en low: no accept, no FSM advance, no counter step. Outputs hold. in_ready = 0.
- in_ready = en && (state == IDLE) && !out_valid. Accept occurs on the edge where in_valid && in_ready.
- FSM states: IDLE, MUL, HOLD.
  - IDLE, accept ADD/SUB/CMP: result registered on the accept edge; go to HOLD with out_valid = 1. Latency is 1 edge.
  - IDLE, accept MUL: latch a and b; clear the accumulator; counter = 0; busy = 1; go to MUL.
  - MUL: each enabled edge, if b_shift[0] then acc += a_shift. Then a_shift <<= 1, b_shift >>= 1, counter++.
  - MUL exit: after W steps, dout = acc, busy = 0, out_valid = 1, go to HOLD. Accept at edge k gives out_valid visible after edge k+W.
  - HOLD: dout and flags stable while out_valid && !out_ready. When out_ready is high on an enabled edge, out_valid drops and the FSM returns to IDLE.
  - A new accept is possible the edge after handoff; no same-edge bypass.
- Arithmetic, all zero-extended to 2W bits:
  - ADD: dout = a + b; carry = dout[W].
  - SUB: dout = (a - b) mod 2^(2W), i.e. two's complement in 2W bits; carry = (a < b).
  - CMP: dout = 0; carry = (a < b); zero = (a == b).
  - MUL: dout = a * b, exact in 2W bits; carry = |dout[2W-1:W].
- zero for ADD/SUB/MUL equals (dout == 0).
- Boundaries:
  - W = 3, a = b = 7: ADD gives 14, carry = 1; MUL gives 49, carry = 1.
  - MUL with b = 0 still takes W cycles and gives zero = 1.
  - out_ready held high from before the result: handoff occurs on the edge after out_valid rises.

Optional Feature:
- Macro: ALU_SAT_SUB_EN
- Defined: SUB saturates. If a < b, dout = 0, carry = 1, zero = 1; otherwise dout = a - b.
- Undefined: SUB wraps modulo 2^(2W) as specified above.
- CMP is unaffected in both cases.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum: OP_SUB = 2'b00, OP_MUL = 2'b01, OP_ADD = 2'b10, OP_CMP = 2'b11;
  - the FSM state typedef (IDLE, MUL, HOLD);
  - the default width constant.
- One sub-module: alu_shift_mul. It contains the iterative multiplier datapath (accumulator, shifters, counter) and its start/done strobes. The top level owns the handshake, the FSM and the flags.

Test Plan:
- W = 3, ADD a = 5, b = 6, out_ready = 1 -> out_valid one edge after accept; dout = 11, carry = 1, zero = 0.
- SUB a = 2, b = 5, macro undefined -> dout = 6'b111101, carry = 1. Same stimulus with ALU_SAT_SUB_EN -> dout = 0, zero = 1.
- MUL a = 7, b = 7 -> busy high for 3 edges, in_ready low throughout; dout = 49, carry = 1. MUL a = 3, b = 0 -> dout = 0, zero = 1, same latency.
- CMP a = 4, b = 4 -> zero = 1, carry = 0. CMP a = 1, b = 6 -> carry = 1, dout = 0.
- Backpressure: ADD result with out_ready = 0 for 5 cycles -> dout and out_valid stable, in_ready = 0. Raise out_ready -> out_valid drops next edge; a new accept is possible on the following edge.
- Control edge cases:
  - en = 0 for 2 cycles mid-MUL -> completion delayed exactly 2 cycles; product correct.
  - rst_n pulsed low mid-MUL -> all outputs 0 immediately, asynchronously; no out_valid afterwards.
